uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8N1 receiver in the CPU I/O path.
//  Supports 5-9 data bits, none/odd/even parity and 1 or 2 stop bits.
//  Flags parity, framing and break errors, and re-arms at mid-stop for back-to-back frames.
//  Feeds the MMIO UART register block; one o_Rx_DV pulse per received frame.
// PARAMETERS
//  CLKS_PER_BIT  1302  clocks per bit = f(i_Clock)/baud; must be >= 8
//  DATA_BITS     8     data bits per frame, 5..9, LSB first
//  PARITY        0     0 none, 1 odd, 2 even
//  STOP_BITS     1     1 or 2
// PORTS
//  i_Clock       in   1          system clock, all logic on rising edge
//  i_Reset       in   1          synchronous, active-high reset
//  i_Rx_Serial   in   1          asynchronous serial line, idle high
//  o_Rx_DV       out  1          one-cycle pulse: frame complete, other outputs valid
//  o_Rx_Byte     out  DATA_BITS  received data, held until next o_Rx_DV
//  o_Parity_Err  out  1          parity mismatch on last frame (0 when PARITY=0)
//  o_Frame_Err   out  1          a stop bit sampled low on last frame
//  o_Break       out  1          last frame: all data, parity and stop samples low
//  o_Busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  - Two-flop synchroniser on i_Rx_Serial (both flops reset to 1); all logic uses the synced line.
//  - Reset: state IDLE, counters 0, o_Rx_DV/o_Parity_Err/o_Frame_Err/o_Break/o_Busy = 0, o_Rx_Byte = 0.
//    Reset mid-frame abandons the frame with no o_Rx_DV.
//  - Bit counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1).
//  - H = (CLKS_PER_BIT-1)/2; all widths sized so no counter wraps.
//  - States and transitions:
//    IDLE:   synced line 0 -> START, count 0.
//    START:  at count==H, line 0 -> DATA, count 0; line 1 -> IDLE (glitch, no output).
//    DATA:   sample at count==CLKS_PER_BIT-1 into bit[index], LSB first; after DATA_BITS samples -> PARITY, or STOP if PARITY=0.
//    PARITY: one bit; sample at count==CLKS_PER_BIT-1; err = (XOR(data)^par) != (PARITY==1).
//    STOP:   STOP_BITS samples at count==CLKS_PER_BIT-1. On the last sample: o_Rx_DV=1; flags and o_Rx_Byte update that edge.
//            Any stop sample 0 -> WAIT_HIGH; else -> IDLE.
//    WAIT_HIGH: stay until synced line 1, then IDLE. Prevents re-triggering during break/low line.
//  - Latency: o_Rx_DV is high in the cycle after edge 3+H+N*CLKS_PER_BIT, counted from the edge
//    that first captures i_Rx_Serial low. N = DATA_BITS + (PARITY!=0) + STOP_BITS.
//  - Error flags are registered with o_Rx_DV and held until the next o_Rx_DV; a frame with an error still pulses o_Rx_DV.
//  - Re-arm at mid-stop: a start edge arriving 0.5 bit after the stop sample is accepted.
//  - Invalid parameter (DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1/2, CLKS_PER_BIT<8): simulation $error at time 0.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//   - Every start/data/parity/stop decision uses the majority of the last 3 synced samples (counts X-2..X).
//   - Rejects a single-cycle glitch at the sample point. Latency is unchanged; adds a 3-bit history register (reset 3'b111).
//  Undefined:
//   - Decision uses the single synced sample at the sample point.
// TESTING (bench: CLKS_PER_BIT=16, so H=7)
//  1. 8N1: send 0xA5 -> o_Rx_DV exactly one cycle, after edge 3+7+9*16=154; o_Rx_Byte=8'hA5; all flags 0.
//  2. 8E1, byte 0x03, parity bit driven 1 -> o_Rx_DV; o_Parity_Err=1; o_Rx_Byte=8'h03.
//     Resend with parity 0 -> o_Parity_Err=0.
//  3. 8N1 stop bit 0, then line low 20 bits -> one o_Rx_DV; o_Frame_Err=1, o_Break=1; o_Busy=1 until line high.
//     No second o_Rx_DV.
//  4. Line low 4 cycles then high -> no o_Rx_DV, o_Busy returns 0 by cycle 10.
//     Then assert i_Reset at bit 3 of a frame -> all outputs 0; next frame 0x3C received correctly.
//  5. 7O2, frames 0x55 then 0x2A back-to-back (2nd start bit 0.5 bit after last stop sample) -> two pulses, data correct, no errors.
//  6. Single-cycle high glitch at mid-bit of data bit 2 of 0x00:
//     with UART_RX_MAJORITY_EN -> 8'h00; without -> 8'h04.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take every bit decision from a 3-sample majority vote.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | confirming start bit at its midpoint
// DATA      | shifting in data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling stop bit(s), publishing the frame
// WAIT_HIGH | stop bit was low, holding until the line is high
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] C_HALF = CW'(H);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 8) begin : g_bad_param
        $error("uart_rx_cfg: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_err;
    logic                 r_stop_low;
    logic                 r_all_low;
    logic                 r_dv;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_perr_o;
    logic                 r_ferr_o;
    logic                 r_brk_o;
    logic                 w_bit;
    logic                 w_stop_low;

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] always equals r_sync2, so the vote spans counts X-2..X
    logic [2:0] r_hist;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_hist <= 3'b111;
        end else begin
            r_hist <= {r_hist[1:0], r_sync1};
        end
    end

    assign w_bit = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
    assign w_bit = r_sync2;
`endif

    assign w_stop_low = r_stop_low | ~w_bit;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_par_err  <= 1'b0;
            r_stop_low <= 1'b0;
            r_all_low  <= 1'b0;
            r_dv       <= 1'b0;
            r_byte     <= '0;
            r_perr_o   <= 1'b0;
            r_ferr_o   <= 1'b0;
            r_brk_o    <= 1'b0;
        end else begin
            r_sync1 <= i_Rx_Serial;
            r_sync2 <= r_sync1;
            r_dv    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        if (!w_bit) begin
                            r_state    <= S_DATA;
                            r_idx      <= '0;
                            r_stop_idx <= 1'b0;
                            r_par_err  <= 1'b0;
                            r_stop_low <= 1'b0;
                            r_all_low  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt     <= '0;
                        r_data    <= {w_bit, r_data[DATA_BITS-1:1]};
                        r_all_low <= r_all_low & ~w_bit;
                        if (r_idx == I_LAST) begin
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt     <= '0;
                        r_par_err <= ((^r_data) ^ w_bit) != ODD;
                        r_all_low <= r_all_low & ~w_bit;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt <= '0;
                        if (r_stop_idx == S_LAST) begin
                            r_dv     <= 1'b1;
                            r_byte   <= r_data;
                            r_perr_o <= r_par_err;
                            r_ferr_o <= w_stop_low;
                            r_brk_o  <= r_all_low & ~w_bit;
                            r_state  <= w_stop_low ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                            r_stop_low <= w_stop_low;
                            r_all_low  <= r_all_low & ~w_bit;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_Rx_DV      = r_dv;
    assign o_Rx_Byte    = r_byte;
    assign o_Parity_Err = r_perr_o;
    assign o_Frame_Err  = r_ferr_o;
    assign o_Break      = r_brk_o;
    assign o_Busy       = (r_state != S_IDLE);

endmodule
